// File: rtl/bcd_subtractor_serial.sv
// bcd_subtractor_serial: digit-serial packed-BCD subtractor, a - b as magnitude plus sign
// Ports: clk, rst (sync, active-high); start, a, b (NDIG-digit packed BCD, digit 0 in [3:0]);
//        busy (operation running), done (1-cycle result pulse), diff (BCD magnitude),
//        neg (a < b), err (invalid-digit flag).
// Optional: define BCD_INVALID_CHECK_EN to reject operands with nibbles above 9 (err=1);
//           otherwise err is tied low.
module bcd_subtractor_serial #(
  parameter int NDIG = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NDIG-1:0]   a,
  input  logic [4*NDIG-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   diff,
  output logic                neg,
  output logic                err
);
  localparam int W = 4 * NDIG;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
  localparam logic [1:0] IDLE = 2'd0, SUB = 2'd1, COMP = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic borrow, bn, last;
  logic [W-1:0] ra, rb, r, r_nxt;
  logic [3:0] x, y, res;
  logic [4:0] t;
  assign busy = state == SUB || state == COMP;
  assign done = state == DONE;
  assign last = idx == LAST;
  // COMP reuses the SUB digit path as 0 - r_i - borrow to form the ten's complement
  always_comb begin
    x = state == SUB ? ra[idx*4 +: 4] : 4'd0;
    y = state == SUB ? rb[idx*4 +: 4] : r[idx*4 +: 4];
    t = {1'b0, x} - {1'b0, y} - {4'd0, borrow};
    bn = t[4];
    res = bn ? t[3:0] + 4'd10 : t[3:0];
    r_nxt = r;
    r_nxt[idx*4 +: 4] = res;
  end
`ifdef BCD_INVALID_CHECK_EN
  logic bad, err_q;
  assign err = err_q;
  always_comb begin
    bad = 1'b0;
    for (int j = 0; j < NDIG; j++) bad = bad | (a[j*4 +: 4] > 4'd9) | (b[j*4 +: 4] > 4'd9);
  end
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      borrow <= 1'b0;
      diff <= '0;
      neg <= 1'b0;
      ra <= '0;
      rb <= '0;
      r <= '0;
`ifdef BCD_INVALID_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        SUB, COMP: begin
          r <= r_nxt;
          idx <= last ? '0 : idx + 1'b1;
          borrow <= last ? 1'b0 : bn;
          if (last) begin
            if (state == SUB && bn) state <= COMP;
            else begin
              diff <= r_nxt;
              neg <= state == COMP;
              state <= DONE;
            end
          end
        end
        default: begin
          if (start) begin
            ra <= a;
            rb <= b;
            idx <= '0;
            borrow <= 1'b0;
            diff <= '0;
            neg <= 1'b0;
            state <= SUB;
`ifdef BCD_INVALID_CHECK_EN
            err_q <= bad;
            if (bad) state <= DONE;
`endif
          end else state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb_bcd_subtractor_serial: scoreboard bench for bcd_subtractor_serial against a decimal model
module tb_bcd_subtractor_serial;
  localparam int N = 2, W = 4 * N;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic busy, done, neg, err;
  int cyc = 0, checks = 0, passed = 0;
  typedef struct {
    logic [W-1:0] d;
    logic n;
    logic e;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  exp_t m;

  bcd_subtractor_serial #(.NDIG(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, want, cyc);
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int s = 0;
    for (int i = N - 1; i >= 0; i--) s = s * 10 + int'(v[i*4 +: 4]);
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit bad(input logic [W-1:0] v);
    bit f = 0;
    for (int i = 0; i < N; i++) if (v[i*4 +: 4] > 4'd9) f = 1;
    return f;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit push);
    exp_t e;
    int d;
    a = xa;
    b = xb;
    start = 1'b1;
    if (push) begin
      d = bcd2int(xa) - bcd2int(xb);
      e.acc = cyc + 1;
      if (bad(xa) || bad(xb)) begin
        e.d = '0; e.n = 1'b0; e.e = 1'b1; e.lat = 1;
      end else begin
        e.d = int2bcd(d < 0 ? -d : d); e.n = d < 0; e.e = 1'b0; e.lat = d < 0 ? 2 * N + 1 : N + 1;
      end
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int k = 0; k < 4 * N + 10 && !got; k++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        m = q.pop_front();
        chk("diff", 32'(diff), 32'(m.d));
        chk("neg", 32'(neg), 32'(m.n));
        chk("err", 32'(err), 32'(m.e));
        chk("latency", 32'(cyc - m.acc + 1), 32'(m.lat));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(8'h93, 8'h12, 1);
    chk("busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_c2", 32'(busy), 32'd1);
    chk("done_c2", 32'(done), 32'd0);
    wait_done();
    @(negedge clk);
    issue(8'h25, 8'h52, 1); wait_done(); @(negedge clk);
    issue(8'h10, 8'h99, 1); wait_done(); @(negedge clk);
    issue(8'h00, 8'h00, 1); wait_done(); @(negedge clk);
    issue(8'h50, 8'h60, 1);
    issue(8'h99, 8'h00, 0);
    wait_done();
    issue(8'h99, 8'h01, 1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("diff_hold", 32'(diff), 32'h98);
    issue(8'h25, 8'h52, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    repeat (8) @(negedge clk);
    issue(8'h44, 8'h11, 1); wait_done(); @(negedge clk);
`ifdef BCD_INVALID_CHECK_EN
    issue(8'h3A, 8'h01, 1); wait_done(); @(negedge clk);
    chk("err_hold", 32'(err), 32'd1);
    issue(8'h12, 8'h03, 1); wait_done(); @(negedge clk);
`endif
    issue(8'h99, 8'h00, 1); wait_done(); @(negedge clk);
    issue(8'h00, 8'h99, 1); wait_done(); @(negedge clk);
    issue(8'h55, 8'h55, 1); wait_done(); @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      issue(rand_bcd(), rand_bcd(), 1);
      wait_done();
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
